// File: rtl/mio_bus_pkg.sv
// Shared definitions for the memory-mapped I/O bus: FSM encoding, slave
// address map (base/mask per slave index) and the value returned by loads
// that decode to no slave.
// Optional feature macro: MIO_BUS_ERR_EN (changes ERR_DATA to 32'hDEAD_BEEF).
package mio_bus_pkg;

    // Upper bound on the number of slave ports the address map describes.
    localparam int MAX_SLV = 16;
    localparam int ADDR_W  = 32;

    // Bus FSM encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } bus_state_t;

    // Data returned by a load to an unmapped address.
`ifdef MIO_BUS_ERR_EN
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] ERR_DATA = 32'h0000_0000;
`endif

    // Slave base addresses. A slave i is hit when (addr & mask) == base.
    // Slave 7 covers the whole 0xF region and overlaps GPIOF on purpose:
    // the lowest index wins, so GPIOF keeps its 256-byte window.
    function automatic logic [ADDR_W-1:0] slv_base(input int idx);
        case (idx)
            0:       slv_base = 32'h0000_0000; // RAM (4 KB)
            1:       slv_base = 32'hF000_0000; // GPIOF
            2:       slv_base = 32'hC000_0000; // VRAM (shared with VGA)
            3:       slv_base = 32'hE000_0000; // GPIOE
            4:       slv_base = 32'hD000_0000; // PS2
            5:       slv_base = 32'hA000_0000; // counter
            6:       slv_base = 32'hB000_0000; // spare
            7:       slv_base = 32'hF000_0000; // catch-all for the 0xF region
            default: slv_base = 32'hFFFF_FFFF; // never matches (mask is 0)
        endcase
    endfunction

    // Slave address masks; paired entry-for-entry with slv_base.
    function automatic logic [ADDR_W-1:0] slv_mask(input int idx);
        case (idx)
            0:       slv_mask = 32'hFFFF_F000;
            1:       slv_mask = 32'hFFFF_FF00;
            2:       slv_mask = 32'hFFE0_0000; // 2 MB = 2^19 words
            3:       slv_mask = 32'hFFFF_FF00;
            4:       slv_mask = 32'hFFFF_FF00;
            5:       slv_mask = 32'hFFFF_FF00;
            6:       slv_mask = 32'hFFFF_FF00;
            7:       slv_mask = 32'hF000_0000;
            default: slv_mask = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/mio_addr_dec.sv
// Combinational address decoder: maps a CPU byte address to a one-hot slave
// hit vector using the base/mask table in mio_bus_pkg. When several slaves
// match, the lowest index is the only one reported. No match raises unmapped.
module mio_addr_dec
    import mio_bus_pkg::*;
#(
    parameter int N_SLV = 8
) (
    input  logic [31:0]      addr,
    output logic [N_SLV-1:0] hit,
    output logic             unmapped
);

    logic found;

    // Priority scan from slave 0 upward; first match claims the access.
    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (!found && ((addr & slv_mask(i)) == slv_base(i))) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign unmapped = ~found;

endmodule

// File: rtl/mio_bus_arb.sv
// Memory-mapped I/O bus between the multi-cycle CPU and its slaves (RAM,
// VRAM, GPIO, counter, PS2). One outstanding CPU access at a time, with a
// configurable slave read latency, and a VRAM port shared with VGA scan-out
// where VGA always has priority.
// Optional feature macro: MIO_BUS_ERR_EN (sticky bus_err flag and
// 32'hDEAD_BEEF on unmapped loads); without it bus_err is tied low.
//
// CPU handshake: the CPU raises cpu_req with cpu_we/cpu_addr/cpu_wdata and
// holds it until it sees cpu_ready. The bus samples the request only in IDLE,
// registers all request fields at that edge (later changes are ignored) and
// answers with exactly one single-cycle cpu_ready pulse; cpu_rdata is valid
// while cpu_ready is high. A request still high in the cycle after cpu_ready
// is taken as a new access; the ready cycle itself never accepts one.
module mio_bus_arb
    import mio_bus_pkg::*;
#(
    parameter int N_SLV    = 8,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int VRAM_IDX = 2,
    parameter int VGA_AW   = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [31:0]             cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_ready,
    output logic [N_SLV-1:0]        slv_sel,
    output logic                    slv_we,
    output logic [31:0]             slv_addr,
    output logic [DATA_W-1:0]       slv_wdata,
    input  logic [N_SLV*DATA_W-1:0] slv_rdata,
    input  logic                    vga_rdn,
    input  logic [VGA_AW-1:0]       vga_addr,
    output logic [VGA_AW-1:0]       vram_addr,
    output logic                    bus_err
);

    // Counter preload: WAIT runs RD_LAT cycles, counting down to 0.
    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    bus_state_t        state;
    logic              req_we;
    logic [N_SLV-1:0]  tgt_hit;
    logic              tgt_err;
    logic [2:0]        lat_cnt;

    logic [N_SLV-1:0]  dec_hit;
    logic              dec_unmapped;
    logic              tgt_vram;
    logic              vga_stall;
    logic [DATA_W-1:0] sel_rdata;

    mio_addr_dec #(
        .N_SLV (N_SLV)
    ) u_dec (
        .addr     (cpu_addr),
        .hit      (dec_hit),
        .unmapped (dec_unmapped)
    );

    // The latched target is VRAM and VGA is reading it right now.
    assign tgt_vram  = tgt_hit[VRAM_IDX];
    assign vga_stall = tgt_vram & ~vga_rdn;

    // VGA owns the VRAM address whenever it asserts its read strobe.
    assign vram_addr = vga_rdn ? slv_addr[VGA_AW+1:2] : vga_addr;

    // Slave strobes come straight from the state register so that an async
    // reset drops them at once; VGA priority gates them in the same cycle.
    assign slv_sel = (state == ST_ACCESS && !vga_stall) ? tgt_hit : '0;
    assign slv_we  = (state == ST_ACCESS) && req_we && !vga_stall && !tgt_err;

    // Read-data mux keyed by the latched one-hot target.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (tgt_hit[i]) begin
                sel_rdata = slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Bus FSM: request capture, slave strobe, read-latency wait, completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_we    <= 1'b0;
            tgt_hit   <= '0;
            tgt_err   <= 1'b0;
            lat_cnt   <= '0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        req_we    <= cpu_we;
                        slv_addr  <= cpu_addr;
                        slv_wdata <= cpu_wdata;
                        tgt_hit   <= dec_hit;
                        tgt_err   <= dec_unmapped;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (tgt_err) begin
                        // Unmapped: stores vanish, loads get the error word.
                        if (!req_we) begin
                            cpu_rdata <= DATA_W'(ERR_DATA);
                        end
                        cpu_ready <= 1'b1;
                        state     <= ST_ERR;
                    end else if (!vga_stall) begin
                        if (req_we) begin
                            cpu_ready <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            lat_cnt <= LAT_INIT;
                            state   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (vga_stall) begin
                        // VGA grabbed VRAM mid-read: the slave data is not ours,
                        // so reissue the access from scratch.
                        state <= ST_ACCESS;
                    end else if (lat_cnt == 3'd0) begin
                        cpu_rdata <= sel_rdata;
                        cpu_ready <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MIO_BUS_ERR_EN
    // Sticky unmapped-access flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if (state == ST_ACCESS && tgt_err) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus_arb.sv
`timescale 1ns/1ps
module tb_mio_bus_arb;

  localparam int N_SLV    = 8;
  localparam int DATA_W   = 32;
  localparam int RD_LAT   = 1;
  localparam int VRAM_IDX = 2;
  localparam int VGA_AW   = 19;

`ifdef MIO_BUS_ERR_EN
  localparam logic [DATA_W-1:0] ERR_VAL = 32'hDEAD_BEEF;
  localparam bit                ERR_EN  = 1'b1;
`else
  localparam logic [DATA_W-1:0] ERR_VAL = 32'h0000_0000;
  localparam bit                ERR_EN  = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic                    cpu_req, cpu_we;
  logic [31:0]             cpu_addr;
  logic [DATA_W-1:0]       cpu_wdata, cpu_rdata;
  logic                    cpu_ready;
  logic [N_SLV-1:0]        slv_sel;
  logic                    slv_we;
  logic [31:0]             slv_addr;
  logic [DATA_W-1:0]       slv_wdata;
  logic [N_SLV*DATA_W-1:0] slv_rdata;
  logic                    vga_rdn;
  logic [VGA_AW-1:0]       vga_addr, vram_addr;
  logic                    bus_err;

  // second instance with RD_LAT = 3
  logic                    cpu_req2;
  logic [DATA_W-1:0]       cpu_rdata2;
  logic                    cpu_ready2;
  logic [N_SLV-1:0]        slv_sel2;
  logic                    slv_we2;
  logic [31:0]             slv_addr2;
  logic [DATA_W-1:0]       slv_wdata2;
  logic [N_SLV*DATA_W-1:0] slv_rdata2;
  logic [VGA_AW-1:0]       vram_addr2;
  logic                    bus_err2;

  mio_bus_arb #(
    .N_SLV(N_SLV), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .VRAM_IDX(VRAM_IDX), .VGA_AW(VGA_AW)
  ) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .slv_sel(slv_sel), .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata), .vga_rdn(vga_rdn), .vga_addr(vga_addr),
    .vram_addr(vram_addr), .bus_err(bus_err)
  );

  mio_bus_arb #(
    .N_SLV(N_SLV), .DATA_W(DATA_W), .RD_LAT(3), .VRAM_IDX(VRAM_IDX), .VGA_AW(VGA_AW)
  ) dut_lat3 (
    .clk(clk), .rst(rst), .cpu_req(cpu_req2), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata2), .cpu_ready(cpu_ready2),
    .slv_sel(slv_sel2), .slv_we(slv_we2), .slv_addr(slv_addr2), .slv_wdata(slv_wdata2),
    .slv_rdata(slv_rdata2), .vga_rdn(vga_rdn), .vga_addr(vga_addr),
    .vram_addr(vram_addr2), .bus_err(bus_err2)
  );

  // ---------------- behavioural slaves ----------------
  // 16-word memory per slave, registered read data that holds until the next read.
  logic [DATA_W-1:0] smem [N_SLV][16] = '{default: '0};
  logic [DATA_W-1:0] srd  [N_SLV]     = '{default: '0};

  always @(posedge clk) begin
    for (int i = 0; i < N_SLV; i++) begin
      if (slv_sel[i]) begin
        if (slv_we) smem[i][slv_addr[5:2]] <= slv_wdata;
        else        srd[i] <= smem[i][slv_addr[5:2]];
      end
    end
  end

  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < N_SLV; i++) slv_rdata[i*DATA_W +: DATA_W] = srd[i];
  end

  // the RD_LAT=3 instance sees fixed per-slave words
  always_comb begin
    slv_rdata2 = '0;
    for (int i = 0; i < N_SLV; i++) slv_rdata2[i*DATA_W +: DATA_W] = 32'hA5A5_0000 | 32'(i);
  end

  int we_cnt = 0;
  always @(negedge clk) if (slv_we) we_cnt <= we_cnt + 1;

  // ---------------- reference model ----------------
  logic [31:0] ref_base [N_SLV] = '{32'h0000_0000, 32'hF000_0000, 32'hC000_0000, 32'hE000_0000,
                                    32'hD000_0000, 32'hA000_0000, 32'hB000_0000, 32'hF000_0000};
  logic [31:0] ref_mask [N_SLV] = '{32'hFFFF_F000, 32'hFFFF_FF00, 32'hFFE0_0000, 32'hFFFF_FF00,
                                    32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hF000_0000};
  // address generator: one region per mapped slave, then two unmapped regions
  logic [31:0] gen_base [10] = '{32'h0000_0000, 32'hF000_0000, 32'hC000_0000, 32'hE000_0000,
                                 32'hD000_0000, 32'hA000_0000, 32'hB000_0000, 32'hF800_0000,
                                 32'h7000_0000, 32'h0000_1000};
  logic [DATA_W-1:0] ref_mem [N_SLV][16] = '{default: '0};
  bit err_seen = 1'b0;

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < N_SLV; i++)
      if ((a & ref_mask[i]) == ref_base[i]) return i;
    return -1;
  endfunction

  // ---------------- scoreboard ----------------
  logic [DATA_W:0] exp_q[$];   // {is_load, expected rdata}
  int              due_q[$];   // expected cpu_ready cycle
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor: every ready pulse pops one expected response
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    int              d;
    if (!rst && cpu_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_ready: actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("ready_cycle", 64'(cyc), 64'(d));
        if (e[DATA_W]) check("load_data", 64'(cpu_rdata), 64'(e[DATA_W-1:0]));
        check("bus_err", 64'(bus_err), 64'(ERR_EN & err_seen));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 in a cycle where the bus is idle; returns at posedge+1
  // of the cycle after cpu_ready with cpu_req still high.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [DATA_W-1:0] wdata, input int extra);
    int s, w, acc;
    bit got;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    acc = cyc;
    s = ref_decode(addr);
    w = int'(addr[5:2]);
    if (s < 0) begin
      err_seen = 1'b1;
      exp_q.push_back({~we, ERR_VAL});
      due_q.push_back(acc + 2 + extra);
    end else if (we) begin
      ref_mem[s][w] = wdata;
      exp_q.push_back({1'b0, {DATA_W{1'b0}}});
      due_q.push_back(acc + 2 + extra);
    end else begin
      exp_q.push_back({1'b1, ref_mem[s][w]});
      due_q.push_back(acc + RD_LAT + 2 + extra);
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (cpu_ready) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL ready_timeout: actual=none required=ready addr=%0h", addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic gap(input int n);
    cpu_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, rcyc, r, w, g;
    bit got;
    rst = 1'b1; cpu_req = 1'b0; cpu_req2 = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    vga_rdn = 1'b0; vga_addr = VGA_AW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(cpu_ready), 64'(0));
    check("rst_rdata", 64'(cpu_rdata), 64'(0));
    check("rst_sel", 64'(slv_sel), 64'(0));
    check("rst_we", 64'(slv_we), 64'(0));
    check("rst_addr", 64'(slv_addr), 64'(0));
    check("rst_wdata", 64'(slv_wdata), 64'(0));
    check("rst_bus_err", 64'(bus_err), 64'(0));
    check("rst_vram_addr", 64'(vram_addr), 64'(vga_addr));
    check("rst_ready2", 64'(cpu_ready2), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; vga_rdn = 1'b1;
    @(posedge clk); #1;

    // RAM store then load, single write strobe
    r = we_cnt;
    issue(1'b1, 32'h0000_0010, 32'h1234_5678, 0);
    check("store_we_pulses", 64'(we_cnt - r), 64'(1));
    issue(1'b0, 32'h0000_0010, '0, 0);
    gap(2);

    // RD_LAT = 3 instance: load slave 1
    cpu_we = 1'b0; cpu_addr = 32'hF000_0000; cpu_req2 = 1'b1;
    acc = cyc; rcyc = -1; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (cpu_ready2) begin got = 1'b1; rcyc = cyc; end
    end
    check("lat3_ready_cycle", 64'(rcyc), 64'(acc + 5));
    check("lat3_data", 64'(cpu_rdata2), 64'(32'hA5A5_0001));
    @(posedge clk); #1;
    cpu_req2 = 1'b0;
    @(posedge clk); #1;

    // VRAM load with VGA holding the port for 4 access cycles
    issue(1'b1, 32'hC000_000C, 32'h0BAD_F00D, 0);
    vga_addr = VGA_AW'($urandom);
    fork
      issue(1'b0, 32'hC000_000C, '0, 4);
      begin
        vga_rdn = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("vga_stall_sel", 64'(slv_sel), 64'(0));
          check("vga_vram_addr", 64'(vram_addr), 64'(vga_addr));
        end
        @(posedge clk); #1;
        vga_rdn = 1'b1;
      end
    join
    check("vram_cpu_addr", 64'(vram_addr), 64'(3));

    // VRAM load preempted during WAIT restarts from ACCESS
    fork
      issue(1'b0, 32'hC000_000C, '0, 2);
      begin
        repeat (2) @(posedge clk);
        #1 vga_rdn = 1'b0;
        @(posedge clk);
        #1 vga_rdn = 1'b1;
      end
    join

    // back-to-back with cpu_req held, across different slaves
    issue(1'b1, 32'hE000_0008, 32'hCAFE_0003, 0);
    issue(1'b1, 32'hF000_0004, 32'hCAFE_0001, 0);
    issue(1'b1, 32'hF800_0004, 32'hCAFE_0007, 0);
    issue(1'b0, 32'hE000_0008, '0, 0);
    issue(1'b0, 32'hF000_0004, '0, 0);
    issue(1'b0, 32'hF800_0004, '0, 0);
    gap(1);

    // unmapped load and store
    issue(1'b0, 32'h7000_0000, '0, 0);
    issue(1'b1, 32'h0000_1000, 32'h5555_AAAA, 0);
    issue(1'b0, 32'h0000_0010, '0, 0);

    // async reset during WAIT: outputs clear at once, no ready follows
    cpu_we = 1'b0; cpu_addr = 32'h0000_0014;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", 64'(cpu_ready), 64'(0));
    check("midrst_rdata", 64'(cpu_rdata), 64'(0));
    check("midrst_sel", 64'(slv_sel), 64'(0));
    check("midrst_addr", 64'(slv_addr), 64'(0));
    check("midrst_bus_err", 64'(bus_err), 64'(0));
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; err_seen = 1'b0;
    gap(4);
    issue(1'b0, 32'h0000_0010, '0, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      w = $urandom_range(0, 15);
      issue(1'($urandom_range(0, 1)), gen_base[r] + 32'(w * 4), $urandom, 0);
      g = $urandom_range(0, 2);
      if (g > 0) gap(g);
    end
    gap(4);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
